eth_frame_tx: RTL and testbench

Ethernet frame transmitter. It is the transmit-side counterpart of the slave frame receiver.
- Accepts header fields plus a byte-stream payload from the MAC client.
- Serialises preamble, SFD, destination/source MAC, EtherType, payload, optional pad and CRC-32 FCS onto a byte-wide line interface.
- Enforces a 12-byte inter-frame gap after every frame.
- Sits between the packet builder and the PHY byte interface.

---
 rtl/eth_pkg.sv | 26 ++
 rtl/eth_frame_tx_if.sv | 30 +++
 rtl/eth_crc32_byte.sv | 21 ++
 rtl/eth_frame_tx.sv | 218 +++++++++++++++++++++
 tb/tb_eth_frame_tx.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared constants and the transmit state type for the Ethernet frame transmitter.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

  localparam int PREAMBLE_LEN = 7;
  localparam int HDR_LEN      = 14;
  localparam int FCS_LEN      = 4;

  // Each state names the line byte being loaded into the output register.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

endpackage

// File: rtl/eth_frame_tx_if.sv
// Client-side bundle of the frame transmitter: frame request, header fields,
// payload stream and the byte-wide line interface.
interface eth_frame_tx_if;

  logic        start;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic        busy;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_last;
  logic        pay_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_err;

  // Packet builder side.
  modport master (
    output start, dst_mac, src_mac, eth_type, pay_data, pay_valid, pay_last,
    input  busy, pay_ready, tx_data, tx_valid, tx_err
  );

  // Transmitter side.
  modport slave (
    input  start, dst_mac, src_mac, eth_type, pay_data, pay_valid, pay_last,
    output busy, pay_ready, tx_data, tx_valid, tx_err
  );

endinterface

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 (reflected 0xEDB88320) advance by one byte, LSB first.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Eight serial shift steps unrolled into one combinational stage.
  always_comb begin
    c = crc_in ^ {24'h0, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet frame transmitter: preamble, SFD, header, payload, optional pad,
// CRC-32 FCS and a fixed inter-frame gap onto a registered byte interface.
// Build option: define ETH_TX_PAD_EN to zero-pad short payloads to MIN_PAYLOAD;
// without it runt frames are sent unpadded.
module eth_frame_tx
  import eth_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1500,
  parameter int MIN_PAYLOAD = 46,
  parameter int IFG_BYTES   = 12
) (
  input logic           clk,
  input logic           rst,
  eth_frame_tx_if.slave bus
);

  // Payload counter wide enough for both the oversize limit and the pad target.
  localparam int PAY_CNT_MAX = (MAX_PAYLOAD > MIN_PAYLOAD) ? MAX_PAYLOAD : MIN_PAYLOAD;
  localparam int PCW         = $clog2(PAY_CNT_MAX + 1);

  localparam logic [PCW-1:0] MAX_LAST = PCW'(MAX_PAYLOAD - 1);
`ifdef ETH_TX_PAD_EN
  localparam logic [PCW-1:0] MIN_LAST = PCW'(MIN_PAYLOAD - 1);
`endif
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] HDR_LAST = 8'(HDR_LEN - 1);
  localparam logic [7:0] FCS_LAST = 8'(FCS_LEN - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  tx_state_e      state;
  logic [7:0]     cnt;
  logic [PCW-1:0] pay_cnt;
  logic [31:0]    crc;
  logic           bad_fcs;

  logic [47:0]    dst_q;
  logic [47:0]    src_q;
  logic [15:0]    type_q;

  logic [7:0]     tx_data_q;
  logic           tx_valid_q;
  logic           tx_err_q;

  logic [111:0]   hdr_vec;
  logic [7:0]     hdr_byte;
  logic [31:0]    fcs_word;
  logic [7:0]     fcs_byte;
  logic [7:0]     crc_byte;
  logic [31:0]    crc_next;
  logic           accept;

  assign accept        = (state == ST_IDLE) && bus.start;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.pay_ready = (state == ST_PAYLOAD);
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_err    = tx_err_q;

  assign hdr_vec  = {dst_q, src_q, type_q};
  // A deliberately corrupted frame sends the raw register instead of its complement.
  assign fcs_word = bad_fcs ? crc : ~crc;

  // Header byte for the current header index, most significant field byte first.
  always_comb begin
    hdr_byte = 8'h00;
    for (int i = 0; i < HDR_LEN; i++) begin
      if (cnt == 8'(i)) hdr_byte = hdr_vec[8*(HDR_LEN-1-i) +: 8];
    end
  end

  // FCS byte for the current FCS index, least significant byte first.
  always_comb begin
    fcs_byte = 8'h00;
    for (int i = 0; i < FCS_LEN; i++) begin
      if (cnt == 8'(i)) fcs_byte = fcs_word[8*i +: 8];
    end
  end

  // Byte fed into the CRC: header, payload (0x00 on underrun) or pad.
  always_comb begin
    crc_byte = 8'h00;
    case (state)
      ST_HEADER:  crc_byte = hdr_byte;
      ST_PAYLOAD: crc_byte = bus.pay_valid ? bus.pay_data : 8'h00;
      default:    crc_byte = 8'h00;
    endcase
  end

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data_in (crc_byte),
    .crc_out (crc_next)
  );

  // Header fields are captured once per frame so later changes wait for the next frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      dst_q  <= bus.dst_mac;
      src_q  <= bus.src_mac;
      type_q <= bus.eth_type;
    end
  end

  // Frame sequencer; the output registers load on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      pay_cnt    <= '0;
      crc        <= CRC_INIT;
      bad_fcs    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_data_q  <= 8'h00;
          tx_valid_q <= 1'b0;
          if (bus.start) begin
            // The first preamble byte is loaded on the accepting edge.
            tx_data_q  <= ETH_PREAMBLE;
            tx_valid_q <= 1'b1;
            cnt        <= 8'd1;
            bad_fcs    <= 1'b0;
            state      <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          tx_data_q  <= ETH_PREAMBLE;
          tx_valid_q <= 1'b1;
          cnt        <= cnt + 8'd1;
          if (cnt == PRE_LAST) state <= ST_SFD;
        end
        ST_SFD: begin
          tx_data_q  <= ETH_SFD;
          tx_valid_q <= 1'b1;
          crc        <= CRC_INIT;
          cnt        <= 8'd0;
          state      <= ST_HEADER;
        end
        ST_HEADER: begin
          tx_data_q  <= hdr_byte;
          tx_valid_q <= 1'b1;
          crc        <= crc_next;
          cnt        <= cnt + 8'd1;
          if (cnt == HDR_LAST) begin
            cnt     <= 8'd0;
            pay_cnt <= '0;
            state   <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          tx_valid_q <= 1'b1;
          crc        <= crc_next;
          cnt        <= 8'd0;
          if (bus.pay_valid) begin
            tx_data_q <= bus.pay_data;
            pay_cnt   <= pay_cnt + 1'b1;
            if (!bus.pay_last && pay_cnt == MAX_LAST) begin
              // Oversize: this byte closes the frame and the rest stays upstream.
              tx_err_q <= 1'b1;
              bad_fcs  <= 1'b1;
              state    <= ST_FCS;
            end else if (bus.pay_last) begin
`ifdef ETH_TX_PAD_EN
              state <= (pay_cnt < MIN_LAST) ? ST_PAD : ST_FCS;
`else
              state <= ST_FCS;
`endif
            end
          end else begin
            // Underrun: fill with zero, flag it and close with a bad FCS, no pad.
            tx_data_q <= 8'h00;
            tx_err_q  <= 1'b1;
            bad_fcs   <= 1'b1;
            state     <= ST_FCS;
          end
        end
`ifdef ETH_TX_PAD_EN
        ST_PAD: begin
          tx_data_q  <= 8'h00;
          tx_valid_q <= 1'b1;
          crc        <= crc_next;
          pay_cnt    <= pay_cnt + 1'b1;
          cnt        <= 8'd0;
          if (pay_cnt == MIN_LAST) state <= ST_FCS;
        end
`endif
        ST_FCS: begin
          tx_data_q  <= fcs_byte;
          tx_valid_q <= 1'b1;
          cnt        <= cnt + 8'd1;
          if (cnt == FCS_LAST) begin
            cnt   <= 8'd0;
            state <= ST_IFG;
          end
        end
        ST_IFG: begin
          tx_data_q  <= 8'h00;
          tx_valid_q <= 1'b0;
          cnt        <= cnt + 8'd1;
          if (cnt == IFG_LAST) begin
            cnt   <= 8'd0;
            state <= ST_IDLE;
          end
        end
        default: begin
          tx_data_q  <= 8'h00;
          tx_valid_q <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Self-checking bench for eth_frame_tx: table-driven frames, random frames
// against a byte-stream reference model, back-to-back and mid-frame reset.
`timescale 1ns/1ps
module tb_eth_frame_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_frame_tx_if bus();

  eth_frame_tx #(.MAX_PAYLOAD(1500), .MIN_PAYLOAD(46), .IFG_BYTES(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int len;
    int under;
    bit last_en;
    int pat;
    int exp_valid;
    int exp_err;
    int err_pos;
    bit good;
  } vec_t;

`ifdef ETH_TX_PAD_EN
  localparam int SHORT1_LEN  = 72;
  localparam int SHORT45_LEN = 72;
  localparam int B2B_LEN     = 72;
`else
  localparam int SHORT1_LEN  = 27;
  localparam int SHORT45_LEN = 71;
  localparam int B2B_LEN     = 31;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] crc_tbl [0:255];
  logic [7:0]  pay_mem [0:2047];
  int src_len, src_under, src_idx, consumed;
  bit src_last_en;

  logic       cv[$];
  logic [7:0] cd[$];
  logic       ce[$];
  logic       cb[$];
  logic [7:0] expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void init_tbl();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[i] = c;
    end
  endfunction

  // Table-driven CRC register (init all-ones, no final inversion) over q[from..to).
  function automatic logic [31:0] crc_q(input logic [7:0] q[$], input int from, input int to);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < to; i++) c = (c >> 8) ^ crc_tbl[c[7:0] ^ q[i]];
    return c;
  endfunction

  task automatic fill_pay(input int len, input int pat);
    for (int i = 0; i < len; i++) begin
      case (pat)
        0:       pay_mem[i] = 8'(i);
        1:       pay_mem[i] = 8'hAB;
        default: pay_mem[i] = 8'($urandom());
      endcase
    end
  endtask

  // Reference frame built directly from the framing rules.
  task automatic build_exp(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                           input int n_pay, input bit under, input bit bad);
    logic [31:0] f;
    expq.delete();
    repeat (7) expq.push_back(8'h55);
    expq.push_back(8'hD5);
    for (int i = 0; i < 6; i++) expq.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) expq.push_back(s[47-8*i -: 8]);
    expq.push_back(t[15:8]);
    expq.push_back(t[7:0]);
    for (int i = 0; i < n_pay; i++) expq.push_back(pay_mem[i]);
    if (under) expq.push_back(8'h00);
`ifdef ETH_TX_PAD_EN
    if (!under) for (int i = n_pay; i < 46; i++) expq.push_back(8'h00);
`endif
    f = ~crc_q(expq, 8, expq.size());
    if (bad) f = ~f;
    for (int i = 0; i < 4; i++) expq.push_back(f[8*i +: 8]);
  endtask

  task automatic drive_src();
    bus.pay_valid = (src_idx < src_len) && (src_idx != src_under);
    bus.pay_data  = (src_idx < src_len) ? pay_mem[src_idx] : 8'h00;
    bus.pay_last  = src_last_en && (src_idx == src_len - 1);
  endtask

  // One clock: sample at the falling edge, update the source just after the rising edge.
  task automatic step();
    bit fire;
    @(negedge clk);
    fire = bus.pay_valid && bus.pay_ready;
    cv.push_back(bus.tx_valid);
    cd.push_back(bus.tx_data);
    ce.push_back(bus.tx_err);
    cb.push_back(bus.busy);
    @(posedge clk);
    #1;
    if (fire) begin
      consumed++;
      src_idx = (src_last_en && src_idx == src_len - 1) ? 0 : src_idx + 1;
    end
    drive_src();
  endtask

  task automatic start_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                             input int len, input int under, input bit last_en, input bit hold);
    bus.dst_mac  = d;
    bus.src_mac  = s;
    bus.eth_type = t;
    src_len = len; src_under = under; src_last_en = last_en; src_idx = 0; consumed = 0;
    drive_src();
    bus.start = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
    cv.delete(); cd.delete(); ce.delete(); cb.delete();
  endtask

  task automatic capture(input int max_cyc, output bit timed_out);
    int idle;
    bit seen;
    idle = 0; seen = 1'b0; timed_out = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      step();
      if (cv[cv.size()-1]) begin seen = 1'b1; idle = 0; end
      else idle++;
      if (seen && idle >= 13) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic run_vec(input string tag, input logic [47:0] d, input logic [47:0] s,
                         input logic [15:0] t, input int len, input int under, input bit last_en,
                         input int exp_valid, input int exp_err, input int err_pos, input bit good);
    int n_pay, n, mism, errs, epos, gap, bz, ncmp;
    bit bad, to;
    logic [31:0] res;
    bad   = (under >= 0) || (!last_en && len > 1500);
    n_pay = (under >= 0) ? under : ((len > 1500) ? 1500 : len);
    build_exp(d, s, t, n_pay, under >= 0, bad);
    start_frame(d, s, t, len, under, last_en, 1'b0);
    capture(4000, to);
    chk({tag, "/capture_timeout"}, 64'(to), 64'd0);
    if (!to) begin
      n = 0;
      while (n < cv.size() && cv[n]) n++;
      chk({tag, "/first_byte"}, {cv[0], cd[0]}, {1'b1, 8'h55});
      chk({tag, "/valid_count"}, 64'(n), 64'(exp_valid));
      ncmp = (under >= 0) ? expq.size() - 4 : expq.size();
      mism = 0;
      for (int i = 0; i < ncmp; i++) if (i >= n || cd[i] !== expq[i]) mism++;
      chk({tag, "/byte_mismatches"}, 64'(mism), 64'd0);
      errs = 0; epos = -1;
      for (int i = 0; i < cv.size(); i++) if (ce[i]) begin errs++; epos = i; end
      chk({tag, "/err_pulses"}, 64'(errs), 64'(exp_err));
      if (exp_err != 0) chk({tag, "/err_pos"}, 64'(epos), 64'(err_pos));
      chk({tag, "/consumed"}, 64'(consumed), 64'(n_pay));
      res = crc_q(cd, 8, n);
      if (good) chk({tag, "/residue"}, 64'(res), 64'(32'hDEBB20E3));
      else      chk({tag, "/residue_bad"}, 64'(res != 32'hDEBB20E3), 64'd1);
      gap = 0;
      for (int i = n; i < n + 12; i++) if (!cv[i]) gap++;
      chk({tag, "/ifg_idle"}, 64'(gap), 64'd12);
      bz = 0;
      for (int i = 0; i < n + 11; i++) if (cb[i]) bz++;
      chk({tag, "/busy_through_ifg"}, 64'(bz), 64'(n + 11));
      chk({tag, "/busy_low_after_ifg"}, 64'(cb[n+11]), 64'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    logic [47:0] d, s, d2, s2;
    logic [15:0] t, t2;
    int len, under, pl, ev, ep, k, runs, mism;
    int rstart[2], rend[2];
    bit inrun, v;

    init_tbl();
    rst = 1'b1;
    bus.start = 1'b0; bus.dst_mac = '0; bus.src_mac = '0; bus.eth_type = '0;
    bus.pay_data = '0; bus.pay_valid = 1'b0; bus.pay_last = 1'b0;
    src_len = 0; src_under = -1; src_idx = 0; consumed = 0; src_last_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("reset/tx_data", 64'(bus.tx_data), 64'd0);
    chk("reset/tx_err", 64'(bus.tx_err), 64'd0);
    chk("reset/busy", 64'(bus.busy), 64'd0);
    chk("reset/pay_ready", 64'(bus.pay_ready), 64'd0);
    rst = 1'b0;
    step();

    // len, under, last_en, pattern, valid bytes, err pulses, err position, good FCS
    vt[0] = '{46,   -1, 1'b1, 0, 72,          0, 0,    1'b1};
    vt[1] = '{1,    -1, 1'b1, 1, SHORT1_LEN,  0, 0,    1'b1};
    vt[2] = '{46,   10, 1'b1, 2, 37,          1, 32,   1'b0};
    vt[3] = '{1501, -1, 1'b0, 2, 1526,        1, 1521, 1'b0};
    vt[4] = '{60,   -1, 1'b1, 2, 86,          0, 0,    1'b1};
    vt[5] = '{1500, -1, 1'b1, 2, 1526,        0, 0,    1'b1};
    vt[6] = '{45,   -1, 1'b1, 2, SHORT45_LEN, 0, 0,    1'b1};

    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        d = 48'hFFFFFFFFFFFF; s = 48'h020000000001; t = 16'h0800;
      end else begin
        d = {16'($urandom()), $urandom()}; s = {16'($urandom()), $urandom()}; t = 16'($urandom());
      end
      fill_pay(vt[i].len, vt[i].pat);
      run_vec($sformatf("vec%0d", i), d, s, t, vt[i].len, vt[i].under, vt[i].last_en,
              vt[i].exp_valid, vt[i].exp_err, vt[i].err_pos, vt[i].good);
    end

    for (int i = 0; i < 8; i++) begin
      len   = $urandom_range(1, 120);
      under = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
`ifdef ETH_TX_PAD_EN
      pl = (len < 46) ? 46 : len;
`else
      pl = len;
`endif
      ev = (under >= 0) ? 8 + 14 + under + 1 + 4 : 8 + 14 + pl + 4;
      ep = (under >= 0) ? 8 + 14 + under : 0;
      d = {16'($urandom()), $urandom()}; s = {16'($urandom()), $urandom()}; t = 16'($urandom());
      fill_pay(len, 2);
      run_vec($sformatf("rand%0d", i), d, s, t, len, under, 1'b1, ev,
              (under >= 0) ? 1 : 0, ep, under < 0);
    end

    // Back-to-back with start held high; header changes while busy apply to the next frame.
    d  = {16'($urandom()), $urandom()}; s  = {16'($urandom()), $urandom()}; t  = 16'($urandom());
    d2 = {16'($urandom()), $urandom()}; s2 = {16'($urandom()), $urandom()}; t2 = 16'($urandom());
    fill_pay(5, 2);
    start_frame(d, s, t, 5, -1, 1'b1, 1'b1);
    bus.dst_mac = d2; bus.src_mac = s2; bus.eth_type = t2;
    runs = 0; inrun = 1'b0; rstart[0] = -1; rstart[1] = -1; rend[0] = -1; rend[1] = -1;
    for (int c = 0; c < 600; c++) begin
      step();
      v = cv[cv.size()-1];
      if (v && !inrun && runs < 2) begin rstart[runs] = cv.size() - 1; runs++; end
      if (!v && inrun) rend[runs-1] = cv.size() - 1;
      inrun = v;
      if (runs == 2 && !v) break;
    end
    bus.start = 1'b0;
    chk("b2b/frames_seen", 64'(runs), 64'd2);
    if (runs == 2 && rend[1] >= 0) begin
      chk("b2b/first_start", 64'(rstart[0]), 64'd0);
      chk("b2b/ifg_gap", 64'(rstart[1] - rend[0]), 64'd12);
      build_exp(d, s, t, 5, 1'b0, 1'b0);
      chk("b2b/frame1_len", 64'(rend[0] - rstart[0]), 64'(B2B_LEN));
      mism = 0;
      for (int i = 0; i < expq.size(); i++) if (cd[rstart[0] + i] !== expq[i]) mism++;
      chk("b2b/frame1_bytes", 64'(mism), 64'd0);
      build_exp(d2, s2, t2, 5, 1'b0, 1'b0);
      chk("b2b/frame2_len", 64'(rend[1] - rstart[1]), 64'(B2B_LEN));
      mism = 0;
      for (int i = 0; i < expq.size(); i++) if (cd[rstart[1] + i] !== expq[i]) mism++;
      chk("b2b/frame2_bytes", 64'(mism), 64'd0);
    end
    repeat (20) step();

    // Reset in the middle of the payload, then a clean frame.
    d = {16'($urandom()), $urandom()}; s = {16'($urandom()), $urandom()}; t = 16'($urandom());
    fill_pay(46, 2);
    start_frame(d, s, t, 46, -1, 1'b1, 1'b0);
    k = 0;
    while (consumed < 20 && k < 200) begin step(); k++; end
    chk("rst/reach_byte20", 64'(consumed), 64'd20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst/tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst/busy", 64'(bus.busy), 64'd0);
    chk("rst/pay_ready", 64'(bus.pay_ready), 64'd0);
    chk("rst/tx_err", 64'(bus.tx_err), 64'd0);
    step();
`ifdef ETH_TX_PAD_EN
    ev = 72;
`else
    ev = 56;
`endif
    fill_pay(30, 2);
    run_vec("rst_clean", d, s, t, 30, -1, 1'b1, ev, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
